median_sort_driver: RTL
=======================

MEDIAN_SORT_DRIVER -- requirements
Module: median_sort_driver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 63: maximum cycles in WAIT_SORT before abort.
REQ-002 SHALL take data width from the shared `BIT_WIDTH macro; it is not a parameter.
REQ-003 CLK  input  1  single clock; all logic rising-edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 pix_valid_i  input  1  upstream pixel valid.
REQ-006 pix_data_i  input  BIT_WIDTH  upstream pixel.
REQ-007 pix_ready_o  output  1  driver accepts a pixel this cycle.
REQ-008 start_o  output  1  sort request to the 9-input sort unit.
REQ-009 win_data0_o..win_data8_o  output  BIT_WIDTH each  window presented to the sort unit.
REQ-010 sort_valid_i  input  1  sort unit done flag.
REQ-011 sort_median_i  input  BIT_WIDTH  sort unit middle output (sorted index 4).
REQ-012 med_valid_o  output  1  median available downstream.
REQ-013 med_data_o  output  BIT_WIDTH  median value.
REQ-014 med_ready_i  input  1  downstream accepts median.
REQ-015 err_timeout_o  output  1  sticky sort-timeout flag.

Function
REQ-016 SHALL implement FSM states COLLECT, WAIT_SORT, RELEASE, OUTPUT.
REQ-017 COLLECT: pix_ready_o=1; each pix_valid_i&pix_ready_o writes pix_data_i to slot idx (0..8), then idx+1.
REQ-018 Acceptance of slot 8 SHALL clear idx to 0 and move to WAIT_SORT on the same edge; no pixel is accepted outside COLLECT.
REQ-019 WAIT_SORT: start_o=1; timeout counter increments each cycle.
REQ-020 WAIT_SORT with sort_valid_i=1 SHALL latch sort_median_i into med_data_o, clear the timeout counter, and go to RELEASE.
REQ-021 WAIT_SORT with a counter value of TIMEOUT_CYC and sort_valid_i=0 SHALL set err_timeout_o, clear the counter, and go to COLLECT; the window is discarded.
REQ-022 RELEASE: start_o=0; SHALL remain until sort_valid_i=0, then go to OUTPUT.
REQ-023 OUTPUT: med_valid_o=1, med_data_o stable; med_ready_i=1 SHALL return to COLLECT.
REQ-024 Valid/ready: med_valid_o SHALL not drop and med_data_o SHALL not change until med_ready_i=1.
REQ-025 win_data0_o..win_data8_o SHALL be unchanged from the entry to WAIT_SORT until the exit from RELEASE.
REQ-026 start_o SHALL be registered and glitch-free; it is 0 in all states except WAIT_SORT.
REQ-027 Latency: start_o rises on the edge that accepts pixel 8.
REQ-027a Latency: med_valid_o rises 2 cycles after sort_valid_i is first seen, provided the sort unit drops sort_valid_i one cycle after start_o falls.
REQ-028 Ports pix_valid_i, sort_valid_i and med_ready_i SHALL each be ignored in every state that does not use that port.
REQ-029 Once set, err_timeout_o SHALL be cleared only by RST.

Reset
REQ-030 RST=1 at an edge SHALL force:
- state COLLECT
- idx 0
- timeout counter 0
- all window slots 0
- start_o 0, med_valid_o 0, med_data_o 0, err_timeout_o 0
REQ-031 RST mid-operation (any state) SHALL drop start_o and med_valid_o on that same edge; no partial window SHALL survive.

Structure
REQ-032 `BIT_WIDTH SHALL come from common.vh; FSM encodings and the slot count of 9 SHALL be localparams in this module.
REQ-033 The 9-slot, write-by-index window register bank SHALL be a sub-module named window_loader, with synchronous active-high reset.
REQ-034 The timeout counter width SHALL be clog2(TIMEOUT_CYC+1), with no wrap-around before the compare.

Verification
REQ-035 Pixels 9,8,7,6,5,4,3,2,1 at one per cycle, with a behavioural sort model -> win_data0..8 = 9..1; start_o high until valid; med_data_o=5, med_valid_o=1.
REQ-036 All nine pixels 200 (BIT_WIDTH=8) -> med_data_o=200; pix_valid_i toggled 1/0 -> exactly nine accepts, idx wraps to 0.
REQ-037 med_ready_i held 0 for 10 cycles in OUTPUT -> med_valid_o=1 and med_data_o constant throughout; pix_ready_o=0; one accept on release.
REQ-038 Sort model never asserts sort_valid_i -> err_timeout_o=1 after 64 WAIT_SORT cycles; start_o=0 next cycle; state COLLECT; flag stays set across the next window.
REQ-039 RST asserted in WAIT_SORT -> next cycle start_o=0, pix_ready_o=1, all win_data=0, err_timeout_o=0.
REQ-040 sort_valid_i held high 3 extra cycles after start_o falls -> stays in RELEASE; med_valid_o rises only after sort_valid_i=0.

Source files
------------

// File: rtl/median_sort_driver_pkg.sv
// Shared widths and helpers for the median sort driver and its window bank.
`include "common.vh"

package median_sort_driver_pkg;
   localparam int unsigned DATA_W = `BIT_WIDTH;
   localparam int unsigned IDX_W  = 4;

   // Counter must hold max_val itself, so size for max_val+1 states.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction
endpackage

// File: rtl/common.vh
// Shared data-width definition for the median filter datapath.
`ifndef COMMON_VH
`define COMMON_VH
`ifndef BIT_WIDTH
`define BIT_WIDTH 8
`endif
`endif

// File: rtl/window_loader.sv
// Write-by-index register bank holding one 3x3 window, cleared by reset.
module window_loader
   import median_sort_driver_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 9
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] slot_o [NUM_SLOTS]
);
   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         logic [DATA_W-1:0] slot_q;
         logic [DATA_W-1:0] slot_d;

         always_comb begin
            slot_d = slot_q;
            if (wr_en && (wr_idx == IDX_W'(gi))) begin
               slot_d = wr_data;
            end
         end

         always_ff @(posedge CLK) begin
            if (RST) begin
               slot_q <= '0;
            end else begin
               slot_q <= slot_d;
            end
         end

         assign slot_o[gi] = slot_q;
      end
   endgenerate
endmodule

// File: rtl/median_sort_driver.sv
// Collects nine pixels, hands the window to an external sort unit and
// forwards its median downstream with valid/ready handshaking.
`include "common.vh"

module median_sort_driver
   import median_sort_driver_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 63
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              pix_valid_i,
   input  logic [DATA_W-1:0] pix_data_i,
   output logic              pix_ready_o,
   output logic              start_o,
   output logic [DATA_W-1:0] win_data0_o,
   output logic [DATA_W-1:0] win_data1_o,
   output logic [DATA_W-1:0] win_data2_o,
   output logic [DATA_W-1:0] win_data3_o,
   output logic [DATA_W-1:0] win_data4_o,
   output logic [DATA_W-1:0] win_data5_o,
   output logic [DATA_W-1:0] win_data6_o,
   output logic [DATA_W-1:0] win_data7_o,
   output logic [DATA_W-1:0] win_data8_o,
   input  logic              sort_valid_i,
   input  logic [DATA_W-1:0] sort_median_i,
   output logic              med_valid_o,
   output logic [DATA_W-1:0] med_data_o,
   input  logic              med_ready_i,
   output logic              err_timeout_o
);
   localparam int unsigned NUM_SLOTS = 9;
   localparam int unsigned CNT_W     = cnt_width(TIMEOUT_CYC);

   localparam logic [1:0] ENC_COLLECT   = 2'd0;
   localparam logic [1:0] ENC_WAIT_SORT = 2'd1;
   localparam logic [1:0] ENC_RELEASE   = 2'd2;
   localparam logic [1:0] ENC_OUTPUT    = 2'd3;

   typedef enum logic [1:0] {
      COLLECT   = ENC_COLLECT,
      WAIT_SORT = ENC_WAIT_SORT,
      RELEASE   = ENC_RELEASE,
      OUTPUT    = ENC_OUTPUT
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              start_q, start_d;
   logic              med_valid_q, med_valid_d;
   logic [DATA_W-1:0] med_data_q, med_data_d;
   logic              err_q, err_d;
   logic              wr_en;
   logic [DATA_W-1:0] slot_w [NUM_SLOTS];

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      start_d     = 1'b0;
      med_valid_d = 1'b0;
      med_data_d  = med_data_q;
      err_d       = err_q;
      wr_en       = 1'b0;
      case (state_q)
         COLLECT: begin
            if (pix_valid_i) begin
               wr_en = 1'b1;
               if (idx_q == IDX_W'(NUM_SLOTS - 1)) begin
                  idx_d   = '0;
                  state_d = WAIT_SORT;
                  start_d = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         WAIT_SORT: begin
            if (sort_valid_i) begin
               med_data_d = sort_median_i;
               cnt_d      = '0;
               state_d    = RELEASE;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
               // Sort unit never answered: drop this window and flag it.
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = COLLECT;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               start_d = 1'b1;
            end
         end
         RELEASE: begin
            if (!sort_valid_i) begin
               state_d     = OUTPUT;
               med_valid_d = 1'b1;
            end
         end
         OUTPUT: begin
            if (med_ready_i) begin
               state_d = COLLECT;
            end else begin
               med_valid_d = 1'b1;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= COLLECT;
         idx_q       <= '0;
         cnt_q       <= '0;
         start_q     <= 1'b0;
         med_valid_q <= 1'b0;
         med_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         start_q     <= start_d;
         med_valid_q <= med_valid_d;
         med_data_q  <= med_data_d;
         err_q       <= err_d;
      end
   end

   window_loader #(
      .NUM_SLOTS(NUM_SLOTS)
   ) u_window_loader (
      .CLK    (CLK),
      .RST    (RST),
      .wr_en  (wr_en),
      .wr_idx (idx_q),
      .wr_data(pix_data_i),
      .slot_o (slot_w)
   );

   assign pix_ready_o   = (state_q == COLLECT);
   assign start_o       = start_q;
   assign med_valid_o   = med_valid_q;
   assign med_data_o    = med_data_q;
   assign err_timeout_o = err_q;

   assign win_data0_o = slot_w[0];
   assign win_data1_o = slot_w[1];
   assign win_data2_o = slot_w[2];
   assign win_data3_o = slot_w[3];
   assign win_data4_o = slot_w[4];
   assign win_data5_o = slot_w[5];
   assign win_data6_o = slot_w[6];
   assign win_data7_o = slot_w[7];
   assign win_data8_o = slot_w[8];
endmodule
